// File: rtl/vga_render.sv
// vga_render: three-stage pixel pipeline that draws the obstacle map, a
// 16-pixel grid, a screen border and a blinking robot marker. All map and
// robot data are taken from a per-frame snapshot latched on the rising edge
// of vsync, so the picture never tears mid-frame. Sync is delayed to match
// the colour latency.
module vga_render #(
  parameter int H_START = 144,
  parameter int V_START = 35,
  parameter int ROBOT_R = 3
) (
  input  logic               I_clk,
  input  logic               I_rst_n,
  input  logic [9:0]         I_h_cnt,
  input  logic [9:0]         I_v_cnt,
  input  logic               I_hs,
  input  logic               I_vs,
  input  logic [1199:0]      I_map,
  input  logic signed [15:0] site_X,
  input  logic signed [15:0] site_Y,
  input  logic [4:0]         state,
  output logic [3:0]         O_red,
  output logic [3:0]         O_green,
  output logic [3:0]         O_blue,
  output logic               O_hs,
  output logic               O_vs
);

  localparam logic signed [16:0] L_R_POS = 17'(ROBOT_R);
  localparam logic signed [16:0] L_R_NEG = -L_R_POS;

  // state bit positions: {search, warning, run, inter, start}
  localparam int L_SEARCH  = 4;
  localparam int L_WARNING = 3;
  localparam int L_RUN     = 2;
  localparam int L_INTER   = 1;
  localparam int L_START   = 0;

  // active-area coordinates; unsigned wrap turns out-of-range counts inactive
  logic [9:0] w_x;
  logic [9:0] w_y;
  logic       w_active;

  assign w_x      = I_h_cnt - 10'(H_START);
  assign w_y      = I_v_cnt - 10'(V_START);
  assign w_active = (w_x < 10'd640) && (w_y < 10'd480);

  // frame snapshot registers
  logic                r_vs_d;
  logic                w_vs_rise;
  logic [1199:0]       r_snap_map;
  logic signed [15:0]  r_snap_x;
  logic signed [15:0]  r_snap_y;
  logic [4:0]          r_snap_state;
  logic [4:0]          r_frame_cnt;

  assign w_vs_rise = I_vs & ~r_vs_d;

  // Latch the frame's map, robot position and state at the end of vsync.
  // The edge detector resets high so a sync line that is idle-high at release
  // is not mistaken for an edge; the robot stays hidden until a real vs rise.
  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      r_vs_d       <= 1'b1;
      r_snap_map   <= '0;
      r_snap_x     <= -16'sd32768;
      r_snap_y     <= -16'sd32768;
      r_snap_state <= '0;
      r_frame_cnt  <= '0;
    end else begin
      r_vs_d <= I_vs;
      if (w_vs_rise) begin
        r_snap_map   <= I_map;
        r_snap_x     <= site_X;
        r_snap_y     <= site_Y;
        r_snap_state <= state;
        r_frame_cnt  <= r_frame_cnt + 5'd1;
      end
    end
  end

  // stage 1: registered coordinates and sync
  logic [9:0] r_s1_x;
  logic [9:0] r_s1_y;
  logic       r_s1_active;
  logic       r_s1_hs;
  logic       r_s1_vs;

  // Register the translated coordinates alongside the sync pulses.
  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      r_s1_x      <= '0;
      r_s1_y      <= '0;
      r_s1_active <= 1'b0;
      r_s1_hs     <= 1'b0;
      r_s1_vs     <= 1'b0;
    end else begin
      r_s1_x      <= w_x;
      r_s1_y      <= w_y;
      r_s1_active <= w_active;
      r_s1_hs     <= I_hs;
      r_s1_vs     <= I_vs;
    end
  end

  // stage 2 combinational lookups: map cell, robot window, grid and border
  logic [5:0]         w_row;
  logic [5:0]         w_col;
  logic [10:0]        w_map_idx;
  logic               w_map_bit;
  logic signed [16:0] w_dx;
  logic signed [16:0] w_dy;
  logic               w_hit;
  logic               w_grid;
  logic               w_border;

  assign w_row     = r_s1_y[9:4];
  assign w_col     = r_s1_x[9:4];
  assign w_map_idx = 11'(w_row) * 11'd40 + 11'(w_col);
  assign w_map_bit = (w_map_idx < 11'd1200) ? r_snap_map[w_map_idx] : 1'b0;
  assign w_dx      = $signed({7'b0, r_s1_x}) - $signed({r_snap_x[15], r_snap_x});
  assign w_dy      = $signed({7'b0, r_s1_y}) - $signed({r_snap_y[15], r_snap_y});
  assign w_hit     = (w_dx >= L_R_NEG) && (w_dx <= L_R_POS) &&
                     (w_dy >= L_R_NEG) && (w_dy <= L_R_POS);
  assign w_grid    = (r_s1_x[3:0] == 4'd0) || (r_s1_y[3:0] == 4'd0);
  assign w_border  = (r_s1_x == 10'd0) || (r_s1_x == 10'd639) ||
                     (r_s1_y == 10'd0) || (r_s1_y == 10'd479);

  // stage 2 registers
  logic r_s2_active;
  logic r_s2_map;
  logic r_s2_hit;
  logic r_s2_grid;
  logic r_s2_border;
  logic r_s2_hs;
  logic r_s2_vs;

  // Register the per-pixel classification flags.
  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      r_s2_active <= 1'b0;
      r_s2_map    <= 1'b0;
      r_s2_hit    <= 1'b0;
      r_s2_grid   <= 1'b0;
      r_s2_border <= 1'b0;
      r_s2_hs     <= 1'b0;
      r_s2_vs     <= 1'b0;
    end else begin
      r_s2_active <= r_s1_active;
      r_s2_map    <= w_map_bit;
      r_s2_hit    <= w_hit;
      r_s2_grid   <= w_grid;
      r_s2_border <= w_border;
      r_s2_hs     <= r_s1_hs;
      r_s2_vs     <= r_s1_vs;
    end
  end

  logic [11:0] w_state_col;
  logic        w_state_show;
  logic [11:0] w_colour;

  // Pick the robot colour from the snapshot state and resolve pixel priority;
  // a warning robot blinks off in the upper half of the frame count and then
  // falls through to the map/grid/black rules.
  always_comb begin
    w_state_col  = 12'h888;
    w_state_show = 1'b1;
    w_colour     = 12'h000;
    if (r_snap_state[L_WARNING]) begin
      w_state_col  = 12'hF00;
      w_state_show = ~r_frame_cnt[4];
    end else if (r_snap_state[L_SEARCH]) begin
      w_state_col = 12'hFF0;
    end else if (r_snap_state[L_RUN]) begin
      w_state_col = 12'h0F0;
    end else if (r_snap_state[L_INTER]) begin
      w_state_col = 12'h0FF;
    end else if (r_snap_state[L_START]) begin
      w_state_col = 12'hFFF;
    end

    if (!r_s2_active) begin
      w_colour = 12'h000;
    end else if (r_s2_border) begin
      w_colour = 12'hFFF;
    end else if (r_s2_hit && w_state_show) begin
      w_colour = w_state_col;
    end else if (r_s2_map) begin
      w_colour = 12'h00A;
    end else if (r_s2_grid) begin
      w_colour = 12'h222;
    end else begin
      w_colour = 12'h000;
    end
  end

  // stage 3: registered colour and sync outputs
  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      O_red   <= '0;
      O_green <= '0;
      O_blue  <= '0;
      O_hs    <= 1'b0;
      O_vs    <= 1'b0;
    end else begin
      O_red   <= w_colour[11:8];
      O_green <= w_colour[7:4];
      O_blue  <= w_colour[3:0];
      O_hs    <= r_s2_hs;
      O_vs    <= r_s2_vs;
    end
  end

endmodule

// File: tb/tb_vga_render.sv
// tb_vga_render: scoreboard bench for vga_render. Each driven pixel pushes its
// expected {colour, hs, vs} with the cycle it should appear on; a negedge
// monitor pops and compares. The bench keeps its own model of the frame
// snapshot, updated whenever it drives a vsync rising edge.
module tb_vga_render;

  localparam int H_START = 144;
  localparam int V_START = 35;
  localparam int ROBOT_R = 3;

  logic               I_clk = 1'b0;
  logic               I_rst_n;
  logic [9:0]         I_h_cnt;
  logic [9:0]         I_v_cnt;
  logic               I_hs;
  logic               I_vs;
  logic [1199:0]      I_map;
  logic signed [15:0] site_X;
  logic signed [15:0] site_Y;
  logic [4:0]         state;
  logic [3:0]         O_red;
  logic [3:0]         O_green;
  logic [3:0]         O_blue;
  logic               O_hs;
  logic               O_vs;

  vga_render #(.H_START(H_START), .V_START(V_START), .ROBOT_R(ROBOT_R)) dut (
    .I_clk   (I_clk),
    .I_rst_n (I_rst_n),
    .I_h_cnt (I_h_cnt),
    .I_v_cnt (I_v_cnt),
    .I_hs    (I_hs),
    .I_vs    (I_vs),
    .I_map   (I_map),
    .site_X  (site_X),
    .site_Y  (site_Y),
    .state   (state),
    .O_red   (O_red),
    .O_green (O_green),
    .O_blue  (O_blue),
    .O_hs    (O_hs),
    .O_vs    (O_vs)
  );

  always #5 I_clk = ~I_clk;

  typedef struct {
    int          due;
    logic [13:0] exp;
    string       tag;
  } entry_t;

  entry_t sbQueue[$];
  entry_t monEntry;
  int     cycleCount = 0;
  int     checkCount = 0;
  int     errorCount = 0;

  // bench model of the frame snapshot
  logic [1199:0] snapMap;
  int            snapX;
  int            snapY;
  logic [4:0]    snapState;
  int            frameCnt;

  // free-running cycle index used to time-stamp expectations
  always @(posedge I_clk) cycleCount <= cycleCount + 1;

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", tag, actual, expected, cycleCount);
    end
  endtask

  // compare the DUT output against the expectation due on this cycle
  always @(negedge I_clk) begin
    if (I_rst_n && sbQueue.size() > 0 && sbQueue[0].due == cycleCount) begin
      monEntry = sbQueue.pop_front();
      checkOutput(monEntry.tag, {18'b0, O_red, O_green, O_blue, O_hs, O_vs},
                  {18'b0, monEntry.exp});
    end
  end

  function automatic logic [11:0] modelColour(input int h, input int v);
    int x, y, dx, dy, idx;
    bit hit;
    x = (h - H_START + 1024) % 1024;
    y = (v - V_START + 1024) % 1024;
    if (x >= 640 || y >= 480) return 12'h000;
    if (x == 0 || x == 639 || y == 0 || y == 479) return 12'hFFF;
    dx  = x - snapX;
    dy  = y - snapY;
    hit = (dx >= -ROBOT_R) && (dx <= ROBOT_R) && (dy >= -ROBOT_R) && (dy <= ROBOT_R);
    if (hit) begin
      if (snapState[3]) begin
        if (frameCnt < 16) return 12'hF00;
      end else if (snapState[4]) return 12'hFF0;
      else if (snapState[2]) return 12'h0F0;
      else if (snapState[1]) return 12'h0FF;
      else if (snapState[0]) return 12'hFFF;
      else return 12'h888;
    end
    idx = (y / 16) * 40 + (x / 16);
    if (snapMap[idx]) return 12'h00A;
    if ((x % 16) == 0 || (y % 16) == 0) return 12'h222;
    return 12'h000;
  endfunction

  function automatic logic hsFor(input int x);
    return (x % 5) != 2;
  endfunction

  task automatic applyStimulus(input int h, input int v, input logic hs,
                               input logic vs, input string tag);
    entry_t e;
    @(posedge I_clk);
    #1;
    I_h_cnt = 10'(h);
    I_v_cnt = 10'(v);
    I_hs    = hs;
    I_vs    = vs;
    e.due   = cycleCount + 3;
    e.exp   = {modelColour(h, v), hs, vs};
    e.tag   = tag;
    sbQueue.push_back(e);
  endtask

  task automatic applyPixel(input int x, input int y, input string tag);
    applyStimulus(x + H_START, y + V_START, hsFor(x), 1'b1, tag);
  endtask

  task automatic resetModel();
    snapMap   = '0;
    snapX     = -32768;
    snapY     = -32768;
    snapState = '0;
    frameCnt  = 0;
  endtask

  // vsync low pulse, then the rising edge that takes the snapshot
  task automatic vsyncPulse();
    for (int i = 0; i < 3; i++) applyStimulus(0, 0, 1'b1, 1'b0, "vsLow");
    applyStimulus(0, 0, 1'b1, 1'b1, "vsRise");
    snapMap   = I_map;
    snapX     = int'(site_X);
    snapY     = int'(site_Y);
    snapState = state;
    frameCnt  = (frameCnt + 1) % 32;
    for (int i = 0; i < 3; i++) applyStimulus(0, 0, 1'b0, 1'b1, "guard");
  endtask

  task automatic setRobot(input int x, input int y, input logic [4:0] st);
    site_X = 16'(x);
    site_Y = 16'(y);
    state  = st;
  endtask

  initial begin
    I_rst_n = 1'b1;
    I_h_cnt = '0;
    I_v_cnt = '0;
    I_hs    = 1'b1;
    I_vs    = 1'b1;
    I_map   = '0;
    resetModel();
    setRobot(100, 50, 5'b00100);
    #2 I_rst_n = 1'b0;
    #1 checkOutput("resetOut", {18'b0, O_red, O_green, O_blue, O_hs, O_vs}, 32'h0);

    // vsync edge while held in reset must not take a snapshot
    I_map[126] = 1'b1;
    repeat (2) @(posedge I_clk);
    #1 I_vs = 1'b0;
    @(posedge I_clk);
    #1 I_vs = 1'b1;
    @(posedge I_clk);
    #1 checkOutput("resetHold", {18'b0, O_red, O_green, O_blue, O_hs, O_vs}, 32'h0);
    @(posedge I_clk);
    #3 I_rst_n = 1'b1;

    // robot and live map hidden before the first snapshot
    applyPixel(100, 50, "hiddenRobot");
    applyPixel(100, 48, "hiddenGrid");

    // latency: border and map pixels
    I_map     = '0;
    I_map[0]  = 1'b1;
    I_map[41] = 1'b1;
    vsyncPulse();
    applyPixel(0, 0, "latBorder");
    applyPixel(16, 16, "latMap");
    applyPixel(32, 40, "latGrid");

    // robot window at (100,50), run state
    for (int x = 95; x <= 105; x++) applyPixel(x, 50, "robotRow");
    for (int y = 45; y <= 55; y++) applyPixel(100, y, "robotCol");
    applyPixel(97, 47, "robotCorner");
    applyPixel(103, 53, "robotCorner");
    applyPixel(104, 53, "robotOut");

    // mid-frame changes are invisible until the next vs rise
    I_map[492] = 1'b1;
    setRobot(200, 180, 5'b00100);
    applyPixel(200, 200, "snapOldMap");
    applyPixel(200, 180, "snapOldSite");
    applyPixel(100, 50, "snapOldRobot");
    vsyncPulse();
    applyPixel(200, 200, "snapNewMap");
    applyPixel(200, 180, "snapNewSite");
    applyPixel(100, 50, "snapNewRobot");

    // warning blink across a full frame-counter wrap
    setRobot(96, 48, 5'b01000);
    for (int f = 0; f < 34; f++) begin
      vsyncPulse();
      applyPixel(96, 48, "warnGrid");
      applyPixel(97, 49, "warnBlack");
    end

    // state colour priority
    begin
      logic [4:0] stList [6];
      stList = '{5'b10000, 5'b00010, 5'b00001, 5'b00000, 5'b10100, 5'b00110};
      for (int s = 0; s < 6; s++) begin
        setRobot(100, 50, stList[s]);
        vsyncPulse();
        applyPixel(100, 50, "stateColour");
      end
    end

    // off-screen and negative positions
    setRobot(-2, -2, 5'b00100);
    vsyncPulse();
    applyPixel(0, 0, "negBorder00");
    applyPixel(1, 0, "negBorder10");
    applyPixel(0, 1, "negBorder01");
    applyPixel(1, 1, "negHit11");
    applyPixel(2, 2, "negMiss22");
    setRobot(-100, 5, 5'b00100);
    vsyncPulse();
    applyPixel(0, 5, "farBorder");
    applyPixel(1, 5, "farMiss");
    setRobot(641, 481, 5'b00100);
    vsyncPulse();
    applyPixel(639, 479, "bigBorder");
    applyPixel(638, 478, "bigHit");
    applyPixel(637, 477, "bigMiss");

    // active-area edges and wrap of out-of-range counts
    applyStimulus(783, 514, 1'b1, 1'b1, "edgeLast");
    applyStimulus(784, 514, 1'b0, 1'b1, "edgeH640");
    applyStimulus(783, 515, 1'b1, 1'b1, "edgeV480");
    applyStimulus(143, 100, 1'b0, 1'b1, "edgeHwrap");
    applyStimulus(300, 34, 1'b1, 1'b1, "edgeVwrap");

    // reset mid-line: clears outputs at once, robot hidden until next vs rise
    setRobot(100, 50, 5'b00100);
    vsyncPulse();
    for (int i = 0; i < 4; i++) applyStimulus(400, 35, 1'b1, 1'b1, "preReset");
    @(posedge I_clk);
    #3 I_rst_n = 1'b0;
    #1 checkOutput("midLineReset", {18'b0, O_red, O_green, O_blue, O_hs, O_vs}, 32'h0);
    sbQueue.delete();
    resetModel();
    repeat (2) @(posedge I_clk);
    #3 I_rst_n = 1'b1;
    applyPixel(100, 50, "postResetHidden");
    applyPixel(256, 0, "postResetBorder");
    vsyncPulse();
    applyPixel(100, 50, "postResetRobot");

    // drain the pipeline
    repeat (5) @(posedge I_clk);
    @(negedge I_clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule
